// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 INCR-burst responder backed by on-chip RAM.
// Independent read and write FSMs, one outstanding burst per direction.
module axi_mem_responder #(
    parameter int unsigned   DW        = 512,
    parameter int unsigned   AW        = 64,
    parameter int unsigned   MEM_BYTES = 65536,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   S_AXI_AWADDR,
    input  logic [7:0]      S_AXI_AWLEN,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [DW-1:0]   S_AXI_WDATA,
    input  logic [DW/8-1:0] S_AXI_WSTRB,
    input  logic            S_AXI_WVALID,
    input  logic            S_AXI_WLAST,
    output logic            S_AXI_WREADY,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [AW-1:0]   S_AXI_ARADDR,
    input  logic [7:0]      S_AXI_ARLEN,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    output logic [DW-1:0]   S_AXI_RDATA,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY
);

    localparam int unsigned NB    = DW / 8;
    localparam int unsigned BW    = $clog2(NB);
    localparam int unsigned DEPTH = MEM_BYTES / NB;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam logic [AW-1:0] MEM_SZ = AW'(MEM_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] aw_off;
    logic [AW-1:0] ar_off;
    logic          aw_hit;
    logic          ar_hit;

    assign aw_off = S_AXI_AWADDR - BASE_ADDR;
    assign ar_off = S_AXI_ARADDR - BASE_ADDR;
    assign aw_hit = (S_AXI_AWADDR >= BASE_ADDR) && (aw_off < MEM_SZ);
    assign ar_hit = (S_AXI_ARADDR >= BASE_ADDR) && (ar_off < MEM_SZ);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RUN}          r_state_t;

    w_state_t      w_state;
    logic [IW-1:0] w_idx;
    logic [7:0]    w_len;
    logic [8:0]    w_cnt;
    logic          w_dec;
    logic          w_slv;
    logic          aw_fire;
    logic          w_fire;
    logic          we;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign we      = w_fire && !w_dec;

    r_state_t      r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt;
    logic          r_dec;
    logic          r_done;
    logic          q_valid;
    logic          q_last;
    logic [DW-1:0] rd_q;
    logic          ar_fire;
    logic          r_fire;
    logic          out_free;
    logic          q_move;
    logic          rd_issue;

    assign ar_fire  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_fire   = S_AXI_RVALID && S_AXI_RREADY;
    assign out_free = !S_AXI_RVALID || S_AXI_RREADY;
    assign q_move   = q_valid && out_free;
    // RAM output acts as the skid stage; only refill it once it can drain
    assign rd_issue = (r_state == R_RUN) && !r_done && (!q_valid || out_free);

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            rd_q <= mem[r_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_dec         <= 1'b0;
            w_slv         <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (aw_fire) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_idx         <= aw_off[BW +: IW];
                        w_len         <= S_AXI_AWLEN;
                        w_cnt         <= '0;
                        w_dec         <= !aw_hit;
                        w_slv         <= 1'b0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= w_idx + IW'(1);
                        w_cnt <= w_cnt + 9'd1;
                        if (S_AXI_WLAST) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            if (w_dec) begin
                                S_AXI_BRESP <= RESP_DECERR;
                            end else if (w_slv || w_cnt != {1'b0, w_len}) begin
                                S_AXI_BRESP <= RESP_SLVERR;
                            end else begin
                                S_AXI_BRESP <= RESP_OKAY;
                            end
                            w_state <= W_RESP;
                        end else if (w_cnt >= {1'b0, w_len}) begin
                            w_slv <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RLAST   <= 1'b0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_dec         <= 1'b0;
            r_done        <= 1'b0;
            q_valid       <= 1'b0;
            q_last        <= 1'b0;
        end else begin
            if (q_move) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= r_dec ? '0 : rd_q;
                S_AXI_RRESP  <= r_dec ? RESP_DECERR : RESP_OKAY;
                S_AXI_RLAST  <= q_last;
            end else if (r_fire) begin
                S_AXI_RVALID <= 1'b0;
                S_AXI_RLAST  <= 1'b0;
            end

            if (rd_issue) begin
                q_valid <= 1'b1;
                q_last  <= (r_cnt == r_len);
                r_idx   <= r_idx + IW'(1);
                r_cnt   <= r_cnt + 8'd1;
                if (r_cnt == r_len) begin
                    r_done <= 1'b1;
                end
            end else if (q_move) begin
                q_valid <= 1'b0;
            end

            unique case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (ar_fire) begin
                        S_AXI_ARREADY <= 1'b0;
                        r_idx         <= ar_off[BW +: IW];
                        r_len         <= S_AXI_ARLEN;
                        r_cnt         <= '0;
                        r_dec         <= !ar_hit;
                        r_done        <= 1'b0;
                        r_state       <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (r_fire && S_AXI_RLAST) begin
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed table plus randomized bursts against a
// byte-array reference memory.
module tb_axi_mem_responder;

    localparam int DW    = 512;
    localparam int AW    = 64;
    localparam int NB    = 64;
    localparam int MEM   = 65536;
    localparam int DEPTH = 1024;
    localparam logic [63:0] BASE = 64'h0;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [AW-1:0]  awaddr;
    logic [7:0]     awlen;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [NB-1:0]  wstrb;
    logic           wvalid;
    logic           wlast;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    axi_mem_responder #(
        .DW(DW), .AW(AW), .MEM_BYTES(MEM), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .resetn(resetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]   ref_mem [MEM];
    logic [511:0] wd [$];
    logic [63:0]  ws [$];
    logic [511:0] rbeats [$];

    typedef struct {
        logic [63:0] addr;
        int          len;
        int          last;
        logic [1:0]  bresp;
    } wvec_t;

    wvec_t wtab [6];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit hit(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < 64'(MEM));
    endfunction

    function automatic int word_at(input logic [63:0] a, input int n);
        logic [63:0] o;
        o = a - BASE;
        return int'(((o / 64'(NB)) + 64'(n)) % 64'(DEPTH));
    endfunction

    function automatic logic [511:0] ref_word(input int w);
        logic [511:0] d;
        for (int b = 0; b < NB; b++) d[8*b +: 8] = ref_mem[w*NB + b];
        return d;
    endfunction

    function automatic void ref_write(input logic [63:0] a, input int nb);
        int w;
        if (!hit(a)) return;
        for (int n = 0; n < nb; n++) begin
            w = word_at(a, n);
            for (int b = 0; b < NB; b++)
                if (ws[n][b]) ref_mem[w*NB + b] = wd[n][8*b +: 8];
        end
    endfunction

    function automatic logic [1:0] ref_bresp(input logic [63:0] a,
                                             input int len, input int last);
        if (!hit(a)) return 2'd3;
        if (last != len) return 2'd2;
        return 2'd0;
    endfunction

    function automatic void load(input int n, input int kind);
        logic [511:0] d;
        wd.delete();
        ws.delete();
        for (int i = 0; i < n; i++) begin
            d = '0;
            case (kind)
                1: d = 512'(i);
                2: for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
                3: d = '1;
                default: d = '0;
            endcase
            wd.push_back(d);
            if (kind == 2) ws.push_back({$urandom, $urandom});
            else if (kind == 3) ws.push_back(64'hFF);
            else ws.push_back('1);
        end
    endfunction

    task automatic axi_write(input logic [63:0] a, input int len,
                             input int last, input bit gaps,
                             output logic [1:0] br);
        int n;
        br = 2'bxx;
        @(negedge clk);
        awaddr = a; awlen = 8'(len); awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) begin
            chk("aw_timeout", 0, 1); awvalid = 1'b0; return;
        end
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= last; b++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                wvalid = 1'b0; @(negedge clk);
            end
            wdata = wd[b]; wstrb = ws[b];
            wlast = (b == last); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) begin
                chk("w_timeout", 0, 1); wvalid = 1'b0; return;
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", bvalid, 1);
        if (gaps) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            chk("b_hold", bvalid, 1);
        end
        br = bresp;
        chk("b_resp", bresp, ref_bresp(a, len, last));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("aw_ready_after_b", awready, 1);
        chk("b_valid_clear", bvalid, 0);
        ref_write(a, last + 1);
    endtask

    // mode 0: RREADY high, 1: alternate 1,0, 2: random
    task automatic axi_read(input logic [63:0] a, input int len,
                            input int mode, input int abort_at);
        logic [511:0] hd;
        logic [1:0]   hr;
        logic         hl;
        logic [511:0] ed;
        bit           held, dec;
        int           n, lat, beat, cyc, bub, pat;
        rbeats.delete();
        dec = !hit(a);
        @(negedge clk);
        araddr = a; arlen = 8'(len); arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) begin
            chk("ar_timeout", 0, 1); arvalid = 1'b0; return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        chk("r_latency", lat, 2);
        beat = 0; cyc = 0; bub = 0; pat = 0; held = 1'b0;
        hd = '0; hr = '0; hl = 1'b0;
        while (beat <= len && cyc < 2000) begin
            if (abort_at >= 0 && beat == abort_at && rvalid) begin
                resetn = 1'b0;
                #1;
                chk("rst_rvalid", rvalid, 0);
                chk("rst_rdata", rdata, 0);
                chk("rst_rlast", rlast, 0);
                chk("rst_arready", arready, 0);
                rready = 1'b0;
                return;
            end
            if (mode == 0) rready = 1'b1;
            else if (mode == 1) rready = (pat % 2 == 0);
            else rready = ($urandom % 3 != 0);
            if (rvalid) begin
                pat++;
                if (held) begin
                    chk("r_stall_data", rdata, hd);
                    chk("r_stall_resp", rresp, hr);
                    chk("r_stall_last", rlast, hl);
                end
                if (rready) begin
                    ed = dec ? '0 : ref_word(word_at(a, beat));
                    chk("r_data", rdata, ed);
                    chk("r_resp", rresp, dec ? 2'd3 : 2'd0);
                    chk("r_last", rlast, beat == len);
                    rbeats.push_back(rdata);
                    beat++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = rdata; hr = rresp; hl = rlast;
                end
            end else begin
                if (held) chk("r_stall_valid", rvalid, 1);
                held = 1'b0;
                bub++;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (beat <= len) chk("r_timeout", beat, len + 1);
        if (mode == 0) chk("r_gapless", bub, 0);
        chk("ar_ready_after_r", arready, 1);
        chk("r_valid_clear", rvalid, 0);
    endtask

    initial begin
        logic [1:0] br;
        logic [63:0] a;
        int len, last, r;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'h00;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        for (int k = 0; k < 4; k++) begin
            load(256, 0);
            axi_write(64'(k * 16384), 255, 255, 1'b0, br);
        end

        load(64, 1);
        axi_write(64'h0, 63, 63, 1'b0, br);
        chk("t1_bresp", br, 2'd0);
        axi_read(64'h0, 63, 0, -1);
        chk("t2_beats", rbeats.size(), 64);

        load(1, 0);
        axi_write(64'h40, 0, 0, 1'b0, br);
        load(1, 3);
        axi_write(64'h40, 0, 0, 1'b0, br);
        axi_read(64'h40, 0, 0, -1);
        chk("t3_word", rbeats[0], {448'b0, 64'hFFFF_FFFF_FFFF_FFFF});

        axi_read(64'h0, 15, 1, -1);
        chk("t5_beat2", rbeats[2], 512'd2);
        chk("t5_beat15", rbeats[15], 512'd15);

        axi_read(64'h0, 63, 0, 10);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_arready", arready, 1);
        chk("t6_awready", awready, 1);
        axi_read(64'h0, 63, 0, -1);

        wtab[0] = '{64'h1000, 7, 3, 2'd2};
        wtab[1] = '{64'h1400, 3, 5, 2'd2};
        wtab[2] = '{64'h10000, 3, 3, 2'd3};
        wtab[3] = '{64'h2013, 0, 0, 2'd0};
        wtab[4] = '{64'hFFC0, 2, 2, 2'd0};
        wtab[5] = '{64'hFFFF_0000_0000_0040, 1, 1, 2'd3};
        for (int i = 0; i < 6; i++) begin
            load(wtab[i].last + 1, 2);
            axi_write(wtab[i].addr, wtab[i].len, wtab[i].last, 1'b1, br);
            chk("tab_bresp", br, wtab[i].bresp);
            if (hit(wtab[i].addr)) begin
                len = (wtab[i].len > wtab[i].last) ? wtab[i].len : wtab[i].last;
                axi_read(wtab[i].addr, len, 2, -1);
            end else begin
                axi_read(wtab[i].addr, 3, 0, -1);
                axi_read(wtab[i].addr & 64'hFFC0, 3, 0, -1);
            end
        end

        load(8, 2);
        fork
            axi_write(64'h8000, 7, 7, 1'b1, br);
            axi_read(64'h0, 15, 2, -1);
        join

        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(0, 15);
            last = len;
            r = $urandom % 6;
            if (r == 0) last = len + 1;
            else if (r == 1 && len > 0) last = len - 1;
            if ($urandom % 8 == 0) a = 64'h10000 + 64'($urandom_range(0, 4095));
            else a = 64'($urandom_range(0, MEM - 1));
            load(last + 1, 2);
            axi_write(a, len, last, 1'b1, br);
            if ($urandom % 2 == 0) a = 64'($urandom_range(0, MEM - 1));
            axi_read(a, $urandom_range(0, 15), 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
